mmc_dat_rx_packer: RTL and testbench
====================================

// Module: mmc_dat_rx_packer
// PURPOSE
//  Sits downstream of the MMC DAT deserialiser in the read path. Packs received bytes
//  (valid/data strobes, no backpressure) into 32-bit little-endian words. Buffers them in
//  a FWFT FIFO, which presents a valid/accept stream to the DMA / register read-out logic.
//  Flags overflow when the consumer stalls.
// PARAMETERS
//  DEPTH   16  FIFO depth in 32-bit words; power of 2, >= 2
//  ADDR_W  4   log2(DEPTH); pointer width
// PORTS
//  clk_i       in   1        system clock
//  rst_i       in   1        synchronous reset, active-high
//  flush_i     in   1        clear packer + FIFO (pulse at start of each transfer)
//  valid_i     in   1        byte strobe from deserialiser (1 cycle)
//  data_i      in   8        received byte, MSB-first serial order already resolved
//  complete_i  in   1        end of transfer; push any partial word zero-padded
//  valid_o     out  1        FIFO head word valid
//  data_o      out  32       FIFO head word
//  accept_i    in   1        consumer takes head word when valid_o & accept_i
//  level_o     out  ADDR_W+1 words currently held (0..DEPTH)
//  overflow_o  out  1        sticky: a word was dropped because FIFO full
// BEHAVIOUR
//  - Reset/flush: byte_cnt=0, shift reg=0, rd/wr ptr=0, count=0, overflow_o=0;
//    valid_o=0, level_o=0, data_o don't-care. flush_i overrides all same-cycle inputs.
//  - Byte lane: byte k of a word (k = byte_cnt 0..3) lands in data[8k+7:8k]; first byte -> [7:0].
//  - byte_cnt: 2-bit, +1 per valid_i, wraps 3->0. On wrap, word {data_i, sr[23:0]} is pushed.
//  - complete_i: if byte_cnt (after including a same-cycle valid_i byte) != 0, push the
//    partial word with unused upper lanes = 0, then byte_cnt=0.
//  - If the same-cycle byte completes a word exactly, only that word is pushed; no pad
//    word is added. At most one push per cycle.
//  - complete_i with byte_cnt==0 and no valid_i: no action.
//  - Push->valid_o latency: 1 cycle (word written on edge, visible next cycle).
//  - FIFO is first-word-fall-through. data_o = mem[rd_ptr]. valid_o = (count != 0).
//  - Pop occurs when valid_o & accept_i. accept_i while !valid_o is ignored.
//  - Push accepted when count < DEPTH, or when count == DEPTH and a pop occurs the
//    same cycle. Otherwise the word is dropped and overflow_o is set until reset/flush.
//  - Simultaneous push+pop: count unchanged, both pointers advance.
//    Pop on empty cannot occur. Push on empty: head valid next cycle.
//  - Pointers wrap modulo DEPTH. count is ADDR_W+1 bits. level_o = count.
//  - No internal state machine beyond byte_cnt and the FIFO. Input strobes are at most
//    1 per cycle and need no handshake.
// TESTING
//  1 Reset, then bytes 11,22,33,44 -> one word 0x44332211. valid_o 1 cycle after last byte.
//    level_o=1.
//  2 512 bytes 0x00..0xFF x2, accept_i=1 -> 128 words in order, overflow_o=0, level_o
//    returns to 0.
//  3 Bytes AA,BB,CC then complete_i -> word 0x00CCBBAA. Byte DD together with complete_i
//    after 3 bytes -> single word 0xDDCCBBAA.
//  4 accept_i=0, push DEPTH+1 words -> level_o=DEPTH, overflow_o=1. First DEPTH words
//    are intact and the last is dropped.
//  5 FIFO full, push and pop in the same cycle -> push accepted, level_o stays DEPTH,
//    overflow_o=0.
//  6 Mid-word (2 bytes) with 3 words queued, flush_i=1 with valid_i=1 -> level_o=0,
//    valid_o=0. The next 4 bytes form a fresh word from lane 0.

Source files
------------

// File: rtl/mmc_dat_rx_packer.sv
// Packs received MMC DAT bytes into 32-bit little-endian words and buffers them
// in a first-word-fall-through FIFO with a sticky overflow flag.
module mmc_dat_rx_packer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [7:0]        data_i,
  input  logic              complete_i,
  output logic              valid_o,
  output logic [31:0]       data_o,
  input  logic              accept_i,
  output logic [ADDR_W:0]   level_o,
  output logic              overflow_o
);

  // Input bytes are unacknowledged strobes (one per cycle at most). The output is a
  // valid/accept stream: a word transfers on any cycle where valid_o & accept_i, and
  // accept_i without valid_o has no effect.

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [1:0]        byte_cnt;
  logic [23:0]       sr;
  logic [1:0]        cnt_nxt;
  logic [23:0]       sr_nxt;
  logic [23:0]       sr_ins;
  logic              push;
  logic [31:0]       push_word;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic              pop;
  logic              push_ok;
  logic              clear;

  assign clear = rst_i | flush_i;

  // Lanes above byte_cnt stay zero because sr is cleared on every push,
  // which gives the zero padding of partial words for free.
  always_comb begin
    sr_ins = sr;
    if (valid_i) begin
      case (byte_cnt)
        2'd0:    sr_ins[7:0]   = data_i;
        2'd1:    sr_ins[15:8]  = data_i;
        2'd2:    sr_ins[23:16] = data_i;
        default: sr_ins        = sr;
      endcase
    end
  end

  always_comb begin
    push      = 1'b0;
    push_word = 32'h0;
    cnt_nxt   = byte_cnt;
    sr_nxt    = sr;
    if (valid_i && byte_cnt == 2'd3) begin
      push      = 1'b1;
      push_word = {data_i, sr};
      cnt_nxt   = 2'd0;
      sr_nxt    = 24'h0;
    end else if (complete_i && (valid_i || byte_cnt != 2'd0)) begin
      push      = 1'b1;
      push_word = {8'h00, sr_ins};
      cnt_nxt   = 2'd0;
      sr_nxt    = 24'h0;
    end else if (valid_i) begin
      cnt_nxt = byte_cnt + 2'd1;
      sr_nxt  = sr_ins;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      byte_cnt <= 2'd0;
      sr       <= 24'h0;
    end else begin
      byte_cnt <= cnt_nxt;
      sr       <= sr_nxt;
    end
  end

  assign pop     = (count != '0) & accept_i;
  assign push_ok = push & ((count < FULL_CNT) | pop);

  // A full FIFO with a same-cycle pop writes into the slot being vacated; the
  // head is read combinationally before the edge, so this is safe.
  always_ff @(posedge clk_i) begin
    if (!clear && push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (push_ok && !pop) begin
        count <= count + (ADDR_W+1)'(1);
      end else if (pop && !push_ok) begin
        count <= count - (ADDR_W+1)'(1);
      end
      if (push && !push_ok) begin
        overflow_o <= 1'b1;
      end
    end
  end

  assign valid_o = (count != '0);
  assign data_o  = mem[rd_ptr];
  assign level_o = count;

endmodule

// File: tb/tb_mmc_dat_rx_packer.sv
// Bench for mmc_dat_rx_packer: directed scenarios plus randomized traffic checked
// cycle by cycle against a queue-based reference model.
module tb_mmc_dat_rx_packer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              valid_i = 1'b0;
  logic [7:0]        data_i = 8'h0;
  logic              complete_i = 1'b0;
  logic              valid_o;
  logic [31:0]       data_o;
  logic              accept_i = 1'b0;
  logic [ADDR_W:0]   level_o;
  logic              overflow_o;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [31:0] exp_q[$];
  logic [7:0]  pend_q[$];
  logic        exp_ovf = 1'b0;
  bit          model_known = 1'b0;
  int          dut_pops = 0;

  always #5 clk = ~clk;

  mmc_dat_rx_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .complete_i (complete_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .accept_i   (accept_i),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bytes gathered so far, lane 0 first, upper lanes zero.
  function automatic logic [31:0] pend_word();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < pend_q.size(); i++) w = w | (32'(pend_q[i]) << (8 * i));
    return w;
  endfunction

  // Called at the negedge: drive inputs, compare outputs against the model,
  // advance the model across the next posedge.
  task automatic cycle(input logic rst, input logic flush, input logic v, input logic [7:0] d,
                       input logic c, input logic a);
    bit          pop;
    bit          have_push;
    logic [31:0] word;
    rst_i = rst; flush_i = flush; valid_i = v; data_i = d; complete_i = c; accept_i = a;
    #1;
    if (model_known) begin
      check_eq("valid_o", 32'(valid_o), 32'(exp_q.size() != 0));
      check_eq("level_o", 32'(level_o), 32'(exp_q.size()));
      check_eq("overflow_o", 32'(overflow_o), 32'(exp_ovf));
      if (exp_q.size() != 0) check_eq("data_o", data_o, exp_q[0]);
      if (valid_o && a) dut_pops++;
    end
    if (rst || flush) begin
      exp_q.delete(); pend_q.delete(); exp_ovf = 1'b0;
      model_known = 1'b1;
    end else begin
      pop = a && exp_q.size() != 0;
      have_push = 1'b0;
      word = 32'h0;
      if (v) pend_q.push_back(d);
      if (pend_q.size() == 4 || (c && pend_q.size() != 0)) begin
        have_push = 1'b1;
        word = pend_word();
        pend_q.delete();
      end
      if (pop) void'(exp_q.pop_front());
      if (have_push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(word);
        else exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic a);
    cycle(1'b0, 1'b0, 1'b1, d, 1'b0, a);
  endtask

  task automatic idle(input logic a);
    cycle(1'b0, 1'b0, 1'b0, 8'h0, 1'b0, a);
  endtask

  task automatic do_flush();
    cycle(1'b0, 1'b1, 1'b0, 8'h0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0);
    check_eq("reset_level", 32'(level_o), 32'd0);
    check_eq("reset_valid", 32'(valid_o), 32'd0);
    check_eq("reset_ovf", 32'(overflow_o), 32'd0);

    // 1: one full word, visible the cycle after the last byte
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    check_eq("t1_not_yet", 32'(valid_o), 32'd0);
    send_byte(8'h44, 1'b0);
    check_eq("t1_valid", 32'(valid_o), 32'd1);
    check_eq("t1_word", data_o, 32'h44332211);
    check_eq("t1_level", 32'(level_o), 32'd1);
    do_flush();

    // 2: 512 streamed bytes with a consumer that never stalls
    dut_pops = 0;
    for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b1);
    idle(1'b1); idle(1'b1);
    check_eq("t2_pops", 32'(dut_pops), 32'd128);
    check_eq("t2_level", 32'(level_o), 32'd0);
    check_eq("t2_ovf", 32'(overflow_o), 32'd0);

    // 3: padded partial word, then a byte that completes a word with complete_i
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h0, 1'b1, 1'b0);
    check_eq("t3_pad_word", data_o, 32'h00CCBBAA);
    idle(1'b1);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b0);
    check_eq("t3_full_word", data_o, 32'hDDCCBBAA);
    check_eq("t3_single_push", 32'(level_o), 32'd1);
    do_flush();

    // 4: stalled consumer, DEPTH+1 words
    for (int i = 0; i < (DEPTH + 1) * 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    check_eq("t4_level", 32'(level_o), 32'(DEPTH));
    check_eq("t4_ovf", 32'(overflow_o), 32'd1);
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    check_eq("t4_drained", 32'(level_o), 32'd0);
    do_flush();

    // 5: push and pop together while full
    for (int i = 0; i < DEPTH * 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    check_eq("t5_level", 32'(level_o), 32'(DEPTH));
    check_eq("t5_ovf", 32'(overflow_o), 32'd0);
    do_flush();

    // 6: flush mid-word with a same-cycle byte
    for (int i = 0; i < 14; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    check_eq("t6_level", 32'(level_o), 32'd0);
    check_eq("t6_valid", 32'(valid_o), 32'd0);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    check_eq("t6_word", data_o, 32'h04030201);

    // randomized traffic; consumer bias varies per segment to reach full/empty
    for (int seg = 0; seg < 8; seg++) begin
      int acc_pct;
      acc_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 95);
      for (int i = 0; i < 400; i++) begin
        cycle(1'b0,
              $urandom_range(0, 299) == 0,
              $urandom_range(0, 99) < 70,
              8'($urandom_range(0, 255)),
              $urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < acc_pct);
      end
    end
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
